jk_pattern_sequencer: RTL and testbench
=======================================

JK_PATTERN_SEQUENCER -- requirements
Module: jk_pattern_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2, giving the cycles each vector is held before results are requested; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins a sweep when sampled high in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: terminates any sweep.
REQ-006 The block SHALL have port ack, input, 1 bit: consumer has checked the current vector.
REQ-007 The block SHALL have ports J, K and sel, each output, 2 bits: stimulus to the downstream JK flip-flop.
REQ-008 The block SHALL have port vec_valid, output, 1 bit: the current vector has been held HOLD_CYCLES and awaits ack.
REQ-009 The block SHALL have port vec_idx, output, 6 bits: step number of the current vector, 0..63.
REQ-010 The block SHALL have port busy, output, 1 bit: high in APPLY and WAIT_ACK.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.

Function
REQ-012 The FSM SHALL have the states IDLE, APPLY, WAIT_ACK and DONE; all outputs SHALL be registered.
REQ-013 IDLE with start=1 and abort=0 SHALL go to APPLY next cycle with step=0; in other states start SHALL be ignored.
REQ-014 In APPLY a hold counter SHALL run for exactly HOLD_CYCLES cycles, then the FSM SHALL go to WAIT_ACK.
REQ-015 In WAIT_ACK vec_valid SHALL be 1; elsewhere it SHALL be 0.
REQ-016 ack in WAIT_ACK SHALL go to DONE when step=63, otherwise step+1 and APPLY; ack in other states SHALL be ignored.
REQ-017 Default vector mapping SHALL be {J,K,sel} = step, i.e. J=step[5:4], K=step[3:2], sel=step[1:0] (J outermost, sel innermost).
REQ-018 J, K and sel SHALL change only on entry to APPLY and SHALL stay stable through APPLY and WAIT_ACK.
REQ-019 DONE SHALL assert done for one cycle, then return to IDLE; J, K and sel SHALL hold their last vector.
REQ-020 abort=1 in any state SHALL go to IDLE next cycle: J=K=sel=0, step=0, no done pulse; abort wins over simultaneous start or ack.
REQ-021 step SHALL never wrap past 63; vec_idx SHALL equal step.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, J=K=sel=2'b00, vec_idx=0, vec_valid=0, busy=0, done=0 and hold counter 0, including mid-sweep.
REQ-023 After rst deasserts, the block SHALL wait for a fresh start.

Configuration
REQ-024 The macro JKSEQ_LFSR_EN SHALL select the vector order.
REQ-025 With JKSEQ_LFSR_EN defined, {J,K,sel} SHALL come from a 6-bit Fibonacci LFSR with taps 6,5 (shift left, new bit = b5^b4), seeded 6'b000001 at each sweep start and advanced on each ack, for steps 0..62; step 63 SHALL apply 6'b000000, so all 64 combinations appear once.
REQ-026 Without JKSEQ_LFSR_EN, the block SHALL use the binary order of REQ-017 and SHALL contain no LFSR logic.

Verification
REQ-027 Reset: assert rst mid-sweep at step 10 -> same cycle busy=0, vec_valid=0, J=K=sel=0; no done.
REQ-028 Full sweep, HOLD_CYCLES=2, ack tied high, binary order: 3 cycles per vector; done pulses 193 cycles after start is sampled; vec_idx 0..63 with {J,K,sel} equal to vec_idx.
REQ-029 Delayed ack: hold ack low 5 cycles at step 7 -> vec_valid stays 1, J/K/sel stable, step stays 7 until ack.
REQ-030 Abort at step 20 together with ack -> IDLE next cycle, outputs zero, no done; a later start restarts at step 0.
REQ-031 start pulsed while busy at step 3 -> no effect; sweep completes normally.
REQ-032 JKSEQ_LFSR_EN defined: step 0 gives J=0,K=0,sel=1; step 1 gives sel=2; step 63 gives 6'b000000; all 64 values are seen with no repeats.

Source files
------------

// File: rtl/jk_pattern_sequencer.sv
// jk_pattern_sequencer: sweeps all 64 {J,K,sel} combinations into a JK flip-flop under test.
// Define JKSEQ_LFSR_EN to apply vectors in 6-bit LFSR order instead of binary order.
module jk_pattern_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       ack,
    output logic [1:0] J,
    output logic [1:0] K,
    output logic [1:0] sel,
    output logic       vec_valid,
    output logic [5:0] vec_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        WAIT_ACK,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    logic [5:0] vec_next;

`ifdef JKSEQ_LFSR_EN
    localparam logic [5:0] FIRST_VEC = 6'd1;

    // Next vector: Fibonacci LFSR (taps 6,5); the final step applies the all-zero vector.
    always_comb begin
        vec_next = {J[0], K, sel, J[1] ^ J[0]};
        if (vec_idx == 6'd62) begin
            vec_next = 6'd0;
        end
    end
`else
    localparam logic [5:0] FIRST_VEC = 6'd0;

    // Next vector: binary order, the vector is simply the step number.
    always_comb begin
        vec_next = vec_idx + 6'd1;
    end
`endif

    // Sweep FSM with all outputs registered; abort behaves like a synchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= 4'd0;
            vec_idx   <= 6'd0;
            J         <= 2'b00;
            K         <= 2'b00;
            sel       <= 2'b00;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            hold_cnt  <= 4'd0;
            vec_idx   <= 6'd0;
            J         <= 2'b00;
            K         <= 2'b00;
            sel       <= 2'b00;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= APPLY;
                        hold_cnt    <= 4'd0;
                        vec_idx     <= 6'd0;
                        {J, K, sel} <= FIRST_VEC;
                        busy        <= 1'b1;
                    end
                end
                APPLY: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= WAIT_ACK;
                        hold_cnt  <= 4'd0;
                        vec_valid <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                WAIT_ACK: begin
                    if (ack) begin
                        vec_valid <= 1'b0;
                        if (vec_idx == 6'd63) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state       <= APPLY;
                            hold_cnt    <= 4'd0;
                            vec_idx     <= vec_idx + 6'd1;
                            {J, K, sel} <= vec_next;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_pattern_sequencer.sv
// Randomized self-checking bench for jk_pattern_sequencer against a sweep-level reference model.
// Build with JKSEQ_LFSR_EN defined to check the LFSR vector order.
module tb_jk_pattern_sequencer;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       ack;
    logic [1:0] J;
    logic [1:0] K;
    logic [1:0] sel;
    logic       vec_valid;
    logic [5:0] vec_idx;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    int ref_vec[64];

    // reference model: sweep running, cycles the vector has been applied,
    // step number, applied vector, done pending, done expected
    int m_run, m_age, m_idx, m_vec, m_pend, m_done;
    int cyc;
    int done_cyc;

    bit seen[64];
    int nseen;

    jk_pattern_sequencer #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .ack(ack),
        .J(J),
        .K(K),
        .sel(sel),
        .vec_valid(vec_valid),
        .vec_idx(vec_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_age  = 0;
        m_idx  = 0;
        m_vec  = 0;
        m_pend = 0;
        m_done = 0;
    endtask

    function automatic int m_valid();
        return (m_run != 0 && m_age >= HOLD) ? 1 : 0;
    endfunction

    // one clock: drive inputs, advance the model, compare every output
    task automatic step_cycle(input logic s, input logic a, input logic k);
        start = s;
        abort = a;
        ack   = k;
        @(posedge clk);
        #1;
        cyc++;
        m_done = 0;
        if (rst || a) begin
            model_reset();
        end else if (m_pend != 0) begin
            m_pend = 0;
            m_done = 1;
        end else if (m_run == 0) begin
            if (s) begin
                m_run = 1;
                m_idx = 0;
                m_age = 0;
                m_vec = ref_vec[0];
            end
        end else if (m_age < HOLD) begin
            m_age++;
        end else if (k) begin
            if (m_idx == 63) begin
                m_run  = 0;
                m_pend = 1;
            end else begin
                m_idx++;
                m_age = 0;
                m_vec = ref_vec[m_idx];
            end
        end
        chk("busy", 32'(busy), 32'(m_run));
        chk("vec_valid", 32'(vec_valid), 32'(m_valid()));
        chk("vec_idx", 32'(vec_idx), 32'(m_idx));
        chk("vec", 32'({J, K, sel}), 32'(m_vec));
        chk("done", 32'(done), 32'(m_done));
        if (done) done_cyc = cyc;
        if (vec_valid && !seen[{J, K, sel}]) begin
            seen[{J, K, sel}] = 1'b1;
            nseen++;
        end
    endtask

    // mode 0: ack tied high; 1: random ack, stalls and stray starts;
    // 2: abort with ack at step 20; 3: stop at step 10 for a reset
    task automatic run_sweep(input int mode);
        int  start_cyc;
        int  w7;
        bit  ended;
        logic s, a, k;
        w7    = 0;
        ended = 0;
        nseen = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        step_cycle(1'b1, 1'b0, 1'b1);
        start_cyc = cyc;
        for (int t = 0; t < 3000; t++) begin
            if (mode == 3 && m_run != 0 && m_idx == 10) begin
                ended = 1;
                break;
            end
            s = 1'b0;
            a = 1'b0;
            k = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
            if (mode == 1 && m_run != 0) begin
                s = 1'(($urandom_range(0, 7) == 0));
                if (m_idx == 3) s = 1'b1;
                if (m_idx == 7 && m_valid() != 0) begin
                    k = 1'(w7 >= 5);
                    w7++;
                end
            end
            if (mode == 2 && m_idx == 20 && m_valid() != 0) begin
                a = 1'b1;
                k = 1'b1;
            end
            step_cycle(s, a, k);
            if (done || a) begin
                ended = 1;
                break;
            end
        end
        chk("sweep_ended", 32'(ended), 32'd1);
        if (mode == 0) begin
            chk("done_latency", 32'(done_cyc - start_cyc), 32'(64 * (HOLD + 1) + 1));
        end
        if (mode == 0 || mode == 1) begin
            chk("distinct_vecs", 32'(nseen), 32'd64);
        end
    endtask

    initial begin
        int v;
`ifdef JKSEQ_LFSR_EN
        v = 1;
        for (int i = 0; i < 63; i++) begin
            ref_vec[i] = v;
            v = ((v * 2) % 64) + (((v / 32) + (v / 16)) % 2);
        end
        ref_vec[63] = 0;
`else
        for (int i = 0; i < 64; i++) ref_vec[i] = i;
`endif
        cyc      = 0;
        done_cyc = 0;
        model_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ack   = 1'b0;
        step_cycle(1'b0, 1'b0, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        step_cycle(1'b0, 1'b0, 1'b1);

        run_sweep(0);
        repeat (3) step_cycle(1'b0, 1'b0, 1'b1);

        run_sweep(1);
        repeat (2) step_cycle(1'b0, 1'b0, 1'b1);

        run_sweep(2);
        repeat (2) step_cycle(1'b0, 1'b0, 1'b1);
        run_sweep(0);

        run_sweep(3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(vec_valid), 32'd0);
        chk("rst_vec", 32'({J, K, sel}), 32'd0);
        chk("rst_idx", 32'(vec_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        model_reset();
        step_cycle(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (3) step_cycle(1'b0, 1'b0, 1'b1);

        run_sweep(1);
        repeat (2) step_cycle(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
